// File: rtl/hit_edge_detector_if.sv
// ---------------------------------------------------------------------------
// Module : hit_edge_detector_if
// Brief  : Pixel/overlap inputs and collision report outputs of hit_edge_detector
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface hit_edge_detector_if;
  logic               startOfFrame;
  logic signed [10:0] pixelX;
  logic signed [10:0] pixelY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               objectDrawingRequest;
  logic               brickDrawingRequest;
  logic               collision;
  logic [3:0]         HitEdgeCode;

  modport master (
    output startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
           objectDrawingRequest, brickDrawingRequest,
    input  collision, HitEdgeCode
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
           objectDrawingRequest, brickDrawingRequest,
    output collision, HitEdgeCode
  );
endinterface

`default_nettype wire

// File: rtl/hit_edge_detector.sv
// ---------------------------------------------------------------------------
// Module : hit_edge_detector
// Brief  : Per-frame object/obstacle overlap detector with edge code and cooldown
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hit_edge_detector #(
  parameter int OBJECT_WIDTH    = 32,
  parameter int OBJECT_HEIGHT   = 32,
  parameter int EDGE_MARGIN     = 4,
  parameter int MIN_HIT_PIXELS  = 2,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  wire logic         clk,
  input  wire logic         resetN,
  hit_edge_detector_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ACCUM    = 2'd0,
    ST_REPORT   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  localparam int                  c_CD_W       = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [c_CD_W-1:0]   c_CD_LOAD    = c_CD_W'(COOLDOWN_FRAMES);
  localparam logic [c_CD_W-1:0]   c_CD_ONE     = c_CD_W'(1);
  localparam logic signed [11:0]  c_LEFT_LIM   = 12'(EDGE_MARGIN);
  localparam logic signed [11:0]  c_RIGHT_LIM  = 12'(OBJECT_WIDTH - EDGE_MARGIN);
  localparam logic signed [11:0]  c_BOTTOM_LIM = 12'(OBJECT_HEIGHT - EDGE_MARGIN);
  localparam logic [15:0]         c_MIN_HITS   = 16'(MIN_HIT_PIXELS);

  state_t              state_q, state_d;
  logic [3:0]          acc_q, acc_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [c_CD_W-1:0]   cd_q, cd_d;
  logic [3:0]          code_q, code_d;

  logic                w_hit;
  logic                w_sof;
  logic signed [11:0]  w_off_x;
  logic signed [11:0]  w_off_y;
  logic [3:0]          w_pix_edges;
  logic                w_frame_ok;

  assign w_hit   = bus.objectDrawingRequest & bus.brickDrawingRequest;
  assign w_sof   = bus.startOfFrame;
  // Sign-extend to 12 bits so the difference of two 11-bit positions never wraps.
  assign w_off_x = {bus.pixelX[10], bus.pixelX} - {bus.topLeftX[10], bus.topLeftX};
  assign w_off_y = {bus.pixelY[10], bus.pixelY} - {bus.topLeftY[10], bus.topLeftY};

  assign w_pix_edges = {(w_off_x <  c_LEFT_LIM),
                        (w_off_y <  c_LEFT_LIM),
                        (w_off_x >= c_RIGHT_LIM),
                        (w_off_y >= c_BOTTOM_LIM)};

  assign w_frame_ok = (cnt_q >= c_MIN_HITS) && (acc_q != 4'b0000);

  // A hit coincident with startOfFrame seeds the new frame instead of the old one.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (w_sof) begin
      acc_d = w_hit ? w_pix_edges : 4'b0000;
      cnt_d = {15'd0, w_hit};
    end else if (w_hit) begin
      acc_d = acc_q | w_pix_edges;
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    code_d  = code_q;
    case (state_q)
      ST_ACCUM: begin
        if (w_sof && w_frame_ok) begin
          state_d = ST_REPORT;
          code_d  = acc_q;
        end
      end
      ST_REPORT: begin
        if (COOLDOWN_FRAMES == 0) begin
          state_d = ST_ACCUM;
        end else if (w_sof) begin
          // Boundary during the report cycle is the first cooldown boundary.
          if (c_CD_LOAD == c_CD_ONE) begin
            state_d = ST_ACCUM;
            cd_d    = '0;
          end else begin
            state_d = ST_COOLDOWN;
            cd_d    = c_CD_LOAD - c_CD_ONE;
          end
        end else begin
          state_d = ST_COOLDOWN;
          cd_d    = c_CD_LOAD;
        end
      end
      ST_COOLDOWN: begin
        if (w_sof) begin
          if (cd_q <= c_CD_ONE) begin
            state_d = ST_ACCUM;
            cd_d    = '0;
          end else begin
            cd_d    = cd_q - c_CD_ONE;
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_ACCUM;
      acc_q   <= 4'b0000;
      cnt_q   <= 16'd0;
      cd_q    <= '0;
      code_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cd_q    <= cd_d;
      code_q  <= code_d;
    end
  end

  assign bus.collision   = (state_q == ST_REPORT);
  assign bus.HitEdgeCode = code_q;

endmodule

`default_nettype wire

// File: tb/tb_hit_edge_detector.sv
// ---------------------------------------------------------------------------
// Module : tb_hit_edge_detector
// Brief  : Directed + randomized self-checking bench for hit_edge_detector
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hit_edge_detector;

  localparam int W   = 32;
  localparam int H   = 32;
  localparam int M   = 4;
  localparam int MIN = 2;
  localparam int CD  = 2;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  hit_edge_detector_if bus ();

  hit_edge_detector #(
    .OBJECT_WIDTH   (W),
    .OBJECT_HEIGHT  (H),
    .EDGE_MARGIN    (M),
    .MIN_HIT_PIXELS (MIN),
    .COOLDOWN_FRAMES(CD)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: frame-level view of the detector.
  int       m_cnt  = 0;
  int       m_skip = 0;
  bit [3:0] m_code = 4'b0;
  bit [3:0] m_hec  = 4'b0;
  bit       m_coll = 1'b0;

  function automatic bit [3:0] edges_of(int px, int py, int tx, int ty);
    int ox, oy;
    ox = px - tx;
    oy = py - ty;
    return {ox < M, oy < M, ox >= W - M, oy >= H - M};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge resetN);
      if (!resetN) begin
        m_cnt = 0; m_skip = 0; m_code = 4'b0; m_hec = 4'b0; m_coll = 1'b0;
      end else begin
        bit       hit, nxt;
        bit [3:0] e;
        hit = bus.objectDrawingRequest && bus.brickDrawingRequest;
        e   = edges_of(int'(bus.pixelX), int'(bus.pixelY), int'(bus.topLeftX), int'(bus.topLeftY));
        nxt = 1'b0;
        if (bus.startOfFrame) begin
          if (m_skip > 0) m_skip = m_skip - 1;
          else if (!m_coll && m_cnt >= MIN && m_code != 4'b0) begin
            nxt = 1'b1; m_hec = m_code; m_skip = CD;
          end
          m_code = hit ? e : 4'b0;
          m_cnt  = hit ? 1 : 0;
        end else if (hit) begin
          m_code = m_code | e;
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        m_coll = nxt;
      end
    end
  end

  task automatic check(string name, logic [3:0] got, logic [3:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("model_collision", {3'b0, bus.collision}, {3'b0, m_coll});
      check("model_edgecode", bus.HitEdgeCode, m_hec);
    end
  end

  task automatic drive(bit sof, int px, int py, bit obj, bit brk);
    bus.startOfFrame         = sof;
    bus.pixelX               = 11'(px);
    bus.pixelY               = 11'(py);
    bus.objectDrawingRequest = obj;
    bus.brickDrawingRequest  = brk;
    @(negedge clk);
  endtask

  task automatic hit_px(int px, int py);
    drive(1'b0, px, py, 1'b1, 1'b1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic sof();
    drive(1'b1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(string name, bit coll, logic [3:0] code);
    check({name, "_coll"}, {3'b0, bus.collision}, {3'b0, coll});
    check({name, "_code"}, bus.HitEdgeCode, code);
  endtask

  initial begin
    bus.startOfFrame = 1'b0;
    bus.pixelX = '0; bus.pixelY = '0;
    bus.topLeftX = 11'sd100; bus.topLeftY = 11'sd100;
    bus.objectDrawingRequest = 1'b0; bus.brickDrawingRequest = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("reset", 1'b0, 4'b0000);
    #2 resetN = 1'b1;
    @(negedge clk);

    // Left edge
    sof(); idle(2);
    hit_px(101, 110); hit_px(102, 110); hit_px(101, 111);
    idle(2);
    sof();
    expect_out("left_report", 1'b1, 4'b1000);
    idle(1);
    expect_out("left_hold", 1'b0, 4'b1000);
    sof(); idle(1); sof(); idle(1);

    // Corner: right + bottom
    hit_px(130, 130); hit_px(131, 131);
    sof();
    expect_out("corner_report", 1'b1, 4'b0011);
    idle(1); sof(); idle(1); sof(); idle(1);

    // Threshold: single edge pixel
    hit_px(101, 110);
    sof();
    expect_out("below_min", 1'b0, 4'b0011);

    // Interior only
    for (int i = 0; i < 5; i++) hit_px(116, 116);
    sof();
    expect_out("interior", 1'b0, 4'b0011);

    // Cooldown: top-edge hits in four frames
    for (int f = 1; f <= 4; f++) begin
      hit_px(110, 101); hit_px(111, 101);
      sof();
      expect_out($sformatf("cooldown_f%0d", f), (f == 1 || f == 4), 4'b0100);
    end
    idle(1); sof(); idle(1); sof(); idle(2);

    // Boundary coincidence: empty prior frame
    drive(1'b1, 101, 110, 1'b1, 1'b1);
    expect_out("coincide_none", 1'b0, 4'b0100);
    hit_px(102, 110);
    sof();
    expect_out("coincide_next", 1'b1, 4'b1000);
    idle(1); sof(); idle(1); sof(); idle(1);

    // Reset mid-frame
    for (int i = 0; i < 10; i++) hit_px(101, 110 + i);
    #2 resetN = 1'b0;
    #1 expect_out("reset_now", 1'b0, 4'b0000);
    @(negedge clk);
    #2 resetN = 1'b1;
    @(negedge clk);
    sof();
    expect_out("reset_after", 1'b0, 4'b0000);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) begin
        bus.topLeftX = 11'($urandom_range(95, 105));
        bus.topLeftY = 11'($urandom_range(95, 105));
      end
      drive($urandom_range(0, 39) == 0,
            int'($urandom_range(85, 145)), int'($urandom_range(85, 145)),
            1'($urandom), 1'($urandom));
      if ($urandom_range(0, 999) == 0) begin
        #2 resetN = 1'b0;
        @(negedge clk);
        #2 resetN = 1'b1;
      end
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
